// File: rtl/alu_cmd_issuer.sv
// Single-outstanding command issuer for the 4-bit ALU: registers operands, waits ALU_LAT cycles, returns result.
// Optional accumulator chaining is built only when ACC_CHAIN_EN is defined.
module alu_cmd_issuer #(
  parameter int WIDTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero
);

  generate
    if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
      $error("alu_cmd_issuer: ALU_LAT must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] a_next;

  // Held low while reset is asserted so every output reads 0 during reset.
  assign cmd_ready = rst_n & ((state == IDLE) | ((state == RESP) & rsp_ready));

`ifdef ACC_CHAIN_EN
  logic [WIDTH-1:0] acc;
  assign a_next = cmd_use_acc ? acc : cmd_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (state == WAIT && cnt == 4'd0) begin
      acc <= alu_result;
    end
  end
`else
  logic unused_use_acc;
  assign unused_use_acc = cmd_use_acc;
  assign a_next         = cmd_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 3'd0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_a  <= a_next;
            alu_b  <= cmd_b;
            alu_op <= cmd_op;
            cnt    <= LAT_M1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= ~|alu_result;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            // A command waiting alongside the response handshake goes straight to WAIT.
            if (cmd_valid) begin
              alu_a  <= a_next;
              alu_b  <= cmd_b;
              alu_op <= cmd_op;
              cnt    <= LAT_M1;
              state  <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: ALU_LAT=1 instance for the main tests, ALU_LAT=3 instance for reset mid-op.
// Expectations for the accumulator test follow ACC_CHAIN_EN.
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic       cmd_use_acc;
  logic       rsp_ready;

  logic       cmd_ready1, rsp_valid1, rsp_carry1, rsp_zero1, alu_carry1;
  logic [3:0] alu_a1, alu_b1, rsp_result1, alu_result1;
  logic [2:0] alu_op1;
  logic       cmd_ready3, rsp_valid3, rsp_carry3, rsp_zero3, alu_carry3;
  logic [3:0] alu_a3, alu_b3, rsp_result3, alu_result3;
  logic [2:0] alu_op3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.WIDTH(4), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
    .alu_result(alu_result1), .alu_carry(alu_carry1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result1), .rsp_carry(rsp_carry1), .rsp_zero(rsp_zero1)
  );

  alu_cmd_issuer #(.WIDTH(4), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .alu_result(alu_result3), .alu_carry(alu_carry3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result3), .rsp_carry(rsp_carry3), .rsp_zero(rsp_zero3)
  );

  // Behavioural 4-bit ALU standing in for the real datapath.
  function automatic logic [4:0] alu_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0:    alu_model = {1'b0, a} + {1'b0, b};
      3'd1:    alu_model = {1'b0, a} - {1'b0, b};
      3'd2:    alu_model = {1'b0, a & b};
      3'd3:    alu_model = {1'b0, a | b};
      3'd4:    alu_model = {1'b0, a ^ b};
      3'd5:    alu_model = {1'b0, a};
      3'd6:    alu_model = {1'b0, b};
      default: alu_model = 5'd0;
    endcase
  endfunction

  assign {alu_carry1, alu_result1} = alu_model(alu_op1, alu_a1, alu_b1);
  assign {alu_carry3, alu_result3} = alu_model(alu_op3, alu_a3, alu_b3);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic use_acc);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = use_acc;
    check("issue_cmd_ready", 32'(cmd_ready1), 32'd1);
    step();
    cmd_valid   = 1'b0;
    cmd_use_acc = 1'b0;
  endtask

  logic [3:0] exp_a, exp_r;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0;
    cmd_use_acc = 1'b0; rsp_ready = 1'b0;
    step(); step();
    check("rst_cmd_ready", 32'(cmd_ready1), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    check("rst_alu_a", 32'(alu_a1), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready1), 32'd1);

    // 1: add with carry, result zero
    rsp_ready = 1'b1;
    issue(3'd0, 4'hF, 4'h1, 1'b0);
    check("add_alu_a", 32'(alu_a1), 32'hF);
    check("add_rsp_valid_early", 32'(rsp_valid1), 32'd0);
    step();
    check("add_rsp_valid", 32'(rsp_valid1), 32'd1);
    check("add_result", 32'(rsp_result1), 32'h0);
    check("add_carry", 32'(rsp_carry1), 32'd1);
    check("add_zero", 32'(rsp_zero1), 32'd1);
    step();
    check("add_rsp_drop", 32'(rsp_valid1), 32'd0);

    // 2: subtract with borrow
    issue(3'd1, 4'h3, 4'h5, 1'b0);
    step();
    check("sub_result", 32'(rsp_result1), 32'hE);
    check("sub_carry", 32'(rsp_carry1), 32'd1);
    check("sub_zero", 32'(rsp_zero1), 32'd0);
    step();

    // 3: backpressure holds the response and blocks new commands
    rsp_ready = 1'b0;
    issue(3'd4, 4'hA, 4'h5, 1'b0);
    step();
    check("bp_result", 32'(rsp_result1), 32'hF);
    cmd_valid = 1'b1; cmd_op = 3'd7;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_rsp_valid", 32'(rsp_valid1), 32'd1);
      check("bp_result_hold", 32'(rsp_result1), 32'hF);
      check("bp_cmd_ready", 32'(cmd_ready1), 32'd0);
    end
    check("bp_alu_op_hold", 32'(alu_op1), 32'd4);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("bp_release_cmd_ready", 32'(cmd_ready1), 32'd1);
    step();
    check("bp_rsp_drop", 32'(rsp_valid1), 32'd0);

    // 4: back-to-back issue with cmd_valid held
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 4'hC; cmd_b = 4'hA;
    step();
    cmd_op = 3'd3;
    check("b2b_wait1", 32'(rsp_valid1), 32'd0);
    step();
    check("b2b_rsp1_valid", 32'(rsp_valid1), 32'd1);
    check("b2b_rsp1_result", 32'(rsp_result1), 32'h8);
    step();
    cmd_valid = 1'b0;
    check("b2b_rsp_gap", 32'(rsp_valid1), 32'd0);
    check("b2b_alu_op2", 32'(alu_op1), 32'd3);
    step();
    check("b2b_rsp2_valid", 32'(rsp_valid1), 32'd1);
    check("b2b_rsp2_result", 32'(rsp_result1), 32'hE);
    step();

    // 6: accumulator chaining (or plain cmd_a when not built)
    issue(3'd0, 4'h2, 4'h3, 1'b0);
    step();
    check("acc_first_result", 32'(rsp_result1), 32'h5);
    step();
`ifdef ACC_CHAIN_EN
    exp_a = 4'h5; exp_r = 4'h9;
`else
    exp_a = 4'h7; exp_r = 4'hB;
`endif
    issue(3'd0, 4'h7, 4'h4, 1'b1);
    check("acc_alu_a", 32'(alu_a1), 32'(exp_a));
    step();
    check("acc_result", 32'(rsp_result1), 32'(exp_r));
    step();

    // 5: reset while the ALU_LAT=3 instance is in WAIT
    rst_n = 1'b0; step(); rst_n = 1'b1; #1;
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'h1; cmd_b = 4'h1;
    check("mid_cmd_ready3", 32'(cmd_ready3), 32'd1);
    step();
    cmd_valid = 1'b0;
    check("mid_alu_a3", 32'(alu_a3), 32'h1);
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid3", 32'(rsp_valid3), 32'd0);
    check("mid_rst_alu_a3", 32'(alu_a3), 32'd0);
    check("mid_rst_alu_b3", 32'(alu_b3), 32'd0);
    check("mid_rst_cmd_ready3", 32'(cmd_ready3), 32'd0);
    step(); step();
    rst_n = 1'b1;
    #1;
    check("mid_release_cmd_ready3", 32'(cmd_ready3), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_no_rsp3", 32'(rsp_valid3), 32'd0);
    end
    check("mid_rsp_result3", 32'(rsp_result3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
